// File: rtl/elevator_floor_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module   : elev_pkg
// Brief    : Shared types for the elevator floor controller: BCD floor pair,
//            FSM state encoding, direction constants and a BCD helper.
// Revision : 1.0 - initial release
// ============================================================================
package elev_pkg;

   localparam int BCD_W = 4;

   typedef struct packed {
      logic [BCD_W-1:0] tens;
      logic [BCD_W-1:0] ones;
   } floor_t;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_PREP  = 3'd1,
      ST_STEP  = 3'd2,
      ST_WAIT  = 3'd3,
      ST_DOOR  = 3'd4,
      ST_FAULT = 3'd5
   } state_t;

   localparam logic DIR_UP = 1'b0;
   localparam logic DIR_DN = 1'b1;

   // Elaboration-time conversion of a binary floor number (0..99) to BCD.
   function automatic floor_t to_bcd(input int unsigned v);
      floor_t f;
      f.tens = BCD_W'((v / 10) % 10);
      f.ones = BCD_W'(v % 10);
      return f;
   endfunction

endpackage
`default_nettype wire

// File: rtl/elevator_floor_controller_if.sv
`default_nettype none
// ============================================================================
// Module   : elevator_floor_controller_if
// Brief    : Floor request handshake between call logic and the controller.
// Revision : 1.0 - initial release
// ============================================================================
interface elevator_floor_controller_if;
   import elev_pkg::*;

   logic             req_valid;
   logic [BCD_W-1:0] req_tens;
   logic [BCD_W-1:0] req_ones;
   logic             req_ready;
   logic             req_err;

   modport master (
      output req_valid, req_tens, req_ones,
      input  req_ready, req_err
   );

   modport slave (
      input  req_valid, req_tens, req_ones,
      output req_ready, req_err
   );

endinterface
`default_nettype wire

// File: rtl/elevator_floor_controller_bcd2_cmp.sv
`default_nettype none
// ============================================================================
// Module   : bcd2_cmp
// Brief    : Combinational two-digit BCD magnitude compare plus digit validity.
// Revision : 1.0 - initial release
// ============================================================================
module bcd2_cmp
   import elev_pkg::*;
(
   input  floor_t a,
   input  floor_t b,
   output logic   eq,
   output logic   gt,
   output logic   lt,
   output logic   a_valid,
   output logic   b_valid
);

   localparam logic [BCD_W-1:0] c_digit_max = BCD_W'(9);

   always_comb begin
      a_valid = (a.tens <= c_digit_max) && (a.ones <= c_digit_max);
      b_valid = (b.tens <= c_digit_max) && (b.ones <= c_digit_max);
      eq      = 1'b0;
      gt      = 1'b0;
      lt      = 1'b0;
      // Tens digit dominates; ones only break a tie.
      if (a.tens != b.tens) begin
         gt = (a.tens > b.tens);
         lt = (a.tens < b.tens);
      end else if (a.ones != b.ones) begin
         gt = (a.ones > b.ones);
         lt = (a.ones < b.ones);
      end else begin
         eq = 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: rtl/elevator_floor_controller.sv
`default_nettype none
// ============================================================================
// Module   : elevator_floor_controller
// Brief    : Drives a BCD floor counter one step at a time toward a requested
//            floor, then holds the door open for a fixed dwell.
// Revision : 1.0 - initial release
// ============================================================================
module elevator_floor_controller
   import elev_pkg::*;
#(
   parameter int STEP_CYCLES = 4,
   parameter int DOOR_CYCLES = 8,
   parameter int MAX_FLOOR   = 20
)(
   input  logic                    clk,
   input  logic                    rst_n,
   elevator_floor_controller_if.slave req,
   input  logic [BCD_W-1:0]        cur_tens,
   input  logic [BCD_W-1:0]        cur_ones,
   output logic                    en_n,
   output logic                    du,
   output logic                    door_open,
   output logic                    arrived,
   output logic                    busy,
   output logic                    fault
);

   localparam int     c_step_w  = $clog2(STEP_CYCLES);
   localparam int     c_door_w  = $clog2(DOOR_CYCLES + 1);
   localparam floor_t c_max_bcd = to_bcd(MAX_FLOOR);

   state_t              r_state;
   state_t              w_state_nx;
   floor_t              r_tgt;
   floor_t              w_req;
   floor_t              w_cur;
   floor_t              w_tgt;
   floor_t              w_lim_a;
   logic [c_step_w-1:0] r_step_cnt;
   logic [c_door_w-1:0] r_door_cnt;
   logic                r_req_ready;
   logic                r_req_err;
   logic                w_accept;
   logic                w_step_last;
   logic                w_door_last;
   logic                w_req_bad;
   logic                w_cur_bad;
   logic                w_err_nx;
   logic                w_du_nx;
   logic                w_mv_eq, w_mv_gt, w_mv_lt, w_tgt_ok, w_cur_ok;
   logic                w_lim_gt, w_lim_eq, w_lim_lt, w_lim_a_ok, w_lim_b_ok;
   logic                w_unused;

   assign w_req    = '{tens: req.req_tens, ones: req.req_ones};
   assign w_cur    = '{tens: cur_tens,     ones: cur_ones};
   assign w_accept = req.req_valid && r_req_ready && (r_state == ST_IDLE);

   // In IDLE both comparators look at the incoming request; once moving they
   // look at the latched target and the live floor.
   assign w_tgt   = (r_state == ST_IDLE) ? w_req : r_tgt;
   assign w_lim_a = (r_state == ST_IDLE) ? w_req : w_cur;

   bcd2_cmp u_cmp_move (
      .a       (w_tgt),
      .b       (w_cur),
      .eq      (w_mv_eq),
      .gt      (w_mv_gt),
      .lt      (w_mv_lt),
      .a_valid (w_tgt_ok),
      .b_valid (w_cur_ok)
   );

   bcd2_cmp u_cmp_limit (
      .a       (w_lim_a),
      .b       (c_max_bcd),
      .eq      (w_lim_eq),
      .gt      (w_lim_gt),
      .lt      (w_lim_lt),
      .a_valid (w_lim_a_ok),
      .b_valid (w_lim_b_ok)
   );

   assign w_unused = &{1'b0, w_mv_lt, w_lim_eq, w_lim_lt, w_lim_a_ok, w_lim_b_ok};

   assign w_req_bad   = !w_tgt_ok || w_lim_gt;
   assign w_cur_bad   = !w_cur_ok || w_lim_gt;
   assign w_step_last = (r_step_cnt == c_step_w'(STEP_CYCLES - 2));
   assign w_door_last = (r_door_cnt == c_door_w'(DOOR_CYCLES - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_nx;
   end

   always_comb begin
      w_state_nx = r_state;
      w_du_nx    = du;
      w_err_nx   = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               if (w_req_bad) begin
                  w_err_nx = 1'b1;
               end else if (!w_cur_ok) begin
                  w_state_nx = ST_FAULT;
               end else if (w_mv_eq) begin
                  w_state_nx = ST_DOOR;
               end else begin
                  w_state_nx = ST_PREP;
                  w_du_nx    = w_mv_gt ? DIR_UP : DIR_DN;
               end
            end
         end
         ST_PREP:  w_state_nx = ST_STEP;
         ST_STEP:  w_state_nx = ST_WAIT;
         ST_WAIT: begin
            if (w_step_last) begin
               if (w_cur_bad)    w_state_nx = ST_FAULT;
               else if (w_mv_eq) w_state_nx = ST_DOOR;
               else              w_state_nx = ST_STEP;
            end
         end
         ST_DOOR: begin
            if (w_door_last) w_state_nx = ST_IDLE;
         end
         ST_FAULT: w_state_nx = ST_FAULT;
         default:  w_state_nx = ST_IDLE;
      endcase
   end

   // Outputs are registered from the next state so they line up with it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         en_n        <= 1'b1;
         du          <= DIR_UP;
         door_open   <= 1'b0;
         arrived     <= 1'b0;
         busy        <= 1'b0;
         fault       <= 1'b0;
         r_req_ready <= 1'b1;
         r_req_err   <= 1'b0;
         r_tgt       <= '0;
         r_step_cnt  <= '0;
         r_door_cnt  <= '0;
      end else begin
         en_n        <= (w_state_nx != ST_STEP);
         du          <= w_du_nx;
         door_open   <= (w_state_nx == ST_DOOR);
         arrived     <= (w_state_nx == ST_DOOR) && (r_state != ST_DOOR);
         busy        <= (w_state_nx != ST_IDLE);
         fault       <= fault || (w_state_nx == ST_FAULT);
         r_req_ready <= (w_state_nx == ST_IDLE);
         r_req_err   <= w_err_nx;
         if (w_accept) r_tgt <= w_req;
         r_step_cnt  <= (r_state == ST_WAIT) ? r_step_cnt + 1'b1 : '0;
         r_door_cnt  <= (r_state == ST_DOOR) ? r_door_cnt + 1'b1 : '0;
      end
   end

   assign req.req_ready = r_req_ready;
   assign req.req_err   = r_req_err;

endmodule
`default_nettype wire
